// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare direction predictor with speculative global history and mispredict repair.
// Optional macro GSHARE_BYPASS_EN forwards a same-cycle counter update to a colliding lookup.
module gshare_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int HIST_BITS  = 4,
    parameter int CNT_BITS   = 2,
    parameter int PC_LSB     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_en,
    input  logic [31:0]           lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_idx,
    output logic [HIST_BITS-1:0]  pred_ghr,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    input  logic [HIST_BITS-1:0]  upd_ghr
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

    logic [CNT_BITS-1:0]   cnt_table [DEPTH];
    logic [HIST_BITS-1:0]  ghr;
    logic [INDEX_BITS-1:0] idx;
    logic [CNT_BITS-1:0]   upd_cur, upd_next, look_cnt;
    logic                  taken;

    always_comb begin
        idx      = lookup_pc[PC_LSB+INDEX_BITS-1:PC_LSB] ^ INDEX_BITS'(ghr);
        upd_cur  = cnt_table[upd_idx];
        upd_next = upd_taken ? ((upd_cur == CNT_MAX) ? upd_cur : upd_cur + CNT_BITS'(1))
                             : ((upd_cur == '0) ? upd_cur : upd_cur - CNT_BITS'(1));
`ifdef GSHARE_BYPASS_EN
        look_cnt = (upd_en && upd_idx == idx) ? upd_next : cnt_table[idx];
`else
        look_cnt = cnt_table[idx];
`endif
        taken    = look_cnt[CNT_BITS-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cnt_table[i] <= CNT_INIT;
            ghr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
            pred_ghr   <= '0;
        end else begin
            if (upd_en) cnt_table[upd_idx] <= upd_next;
            // truncating the concatenation drops the oldest bit, which also covers HIST_BITS=1
            if (upd_en && upd_mispredict) ghr <= HIST_BITS'({upd_ghr, upd_taken});
            else if (lookup_en) ghr <= HIST_BITS'({ghr, taken});
            pred_valid <= lookup_en;
            if (lookup_en) begin
                pred_taken <= taken;
                pred_idx   <= idx;
                pred_ghr   <= ghr;
            end
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed vectors checked against a per-cycle reference model plus literal expectations.
module tb_gshare_predictor;
    logic        clk = 1'b0;
    logic        rst, lookup_en, upd_en, upd_taken, upd_mispredict;
    logic [31:0] lookup_pc;
    logic [3:0]  upd_idx, upd_ghr, pred_idx, pred_ghr;
    logic        pred_valid, pred_taken;

    int errors = 0;
    int checks = 0;
    int m_cnt [16];
    int m_ghr;
    int e_valid, e_taken, e_idx, e_ghr;

`ifdef GSHARE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk(clk), .rst(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr)
    );

    function automatic int sat(int c, int t);
        return t ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(int r, int le, logic [31:0] pc, int ue, int ui, int ut, int um, int ug);
        int idx, c, tk;
        rst = 1'(r); lookup_en = 1'(le); lookup_pc = pc;
        upd_en = 1'(ue); upd_idx = 4'(ui); upd_taken = 1'(ut); upd_mispredict = 1'(um); upd_ghr = 4'(ug);
        if (r != 0) begin
            foreach (m_cnt[i]) m_cnt[i] = 1;
            m_ghr = 0; e_valid = 0; e_taken = 0; e_idx = 0; e_ghr = 0;
        end else begin
            idx = int'(pc[5:2]) ^ m_ghr;
            c = m_cnt[idx];
            if (BYP != 0 && ue != 0 && ui == idx) c = sat(c, ut);
            tk = (c >= 2) ? 1 : 0;
            e_valid = le;
            if (le != 0) begin e_taken = tk; e_idx = idx; e_ghr = m_ghr; end
            if (ue != 0) m_cnt[ui] = sat(m_cnt[ui], ut);
            if (ue != 0 && um != 0) m_ghr = ((ug << 1) | ut) & 15;
            else if (le != 0) m_ghr = ((m_ghr << 1) | tk) & 15;
        end
        @(posedge clk);
        #1;
        check("model_valid", pred_valid, e_valid);
        if (e_valid != 0 || r != 0) begin
            check("model_taken", pred_taken, e_taken);
            check("model_idx", pred_idx, e_idx);
            check("model_ghr", pred_ghr, e_ghr);
        end
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_valid", pred_valid, 0);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        check("first_valid", pred_valid, 1);
        check("first_taken", pred_taken, 0);
        check("first_idx", pred_idx, 0);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        check("second_ghr", pred_ghr, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 5, 1, 0, 0);
        step(0, 1, 32'h14, 0, 0, 0, 0, 0);
        check("sat_up_taken", pred_taken, 1);
        check("sat_up_idx", pred_idx, 5);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5, 0, 0, 0);
        step(0, 1, 32'h10, 0, 0, 0, 0, 0);
        check("sat_down_idx", pred_idx, 5);
        check("sat_down_taken", pred_taken, 0);
        check("sat_down_ghr", pred_ghr, 1);
        step(0, 0, 0, 1, 15, 1, 1, 1);
        step(0, 1, 32'h14, 0, 0, 0, 0, 0);
        check("index_idx", pred_idx, 6);
        check("index_ghr", pred_ghr, 3);
        step(0, 1, 32'h0, 1, 0, 0, 1, 10);
        check("prio_pred_idx", pred_idx, 6);
        step(0, 1, 32'h0, 0, 0, 0, 0, 0);
        check("prio_ghr", pred_ghr, 4);
        check("prio_idx", pred_idx, 4);
        step(0, 1, 32'h2C, 1, 3, 1, 0, 0);
        check("bypass_idx", pred_idx, 3);
        check("bypass_taken", pred_taken, BYP);
        step(1, 1, 32'h14, 0, 0, 0, 0, 0);
        check("midrst_valid", pred_valid, 0);
        step(0, 1, 32'h14, 0, 0, 0, 0, 0);
        check("midrst_idx", pred_idx, 5);
        check("midrst_ghr", pred_ghr, 0);
        step(0, 0, 0, 1, 5, 1, 0, 0);
        step(0, 1, 32'h14, 0, 0, 0, 0, 0);
        check("midrst_cnt", pred_taken, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_valid", pred_valid, 0);
        for (int i = 0; i < 60; i++)
            step(0, (i % 4) != 3, 32'(i * 28), (i % 3) == 0, (i * 5) % 16, (i % 7) < 4, (i % 5) == 0, (i * 3) % 16);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare direction predictor: a table of 2^INDEX_BITS saturating counters of CNT_BITS each, indexed by PC XOR a speculative global history register (GHR). It sits beside the fetch stage. Fetch issues a lookup and gets a registered prediction one cycle later. The execute stage returns resolved outcomes to train the counters and, on a mispredict, to repair the GHR. It generalises the per-branch 2-bit history table to configurable depth, counter width and history length, and adds speculative history with recovery.

## Interface
- INDEX_BITS, 4, log2 of table depth.
- HIST_BITS, 4, GHR length; legal range 1..INDEX_BITS.
- CNT_BITS, 2, counter width; minimum 2.
- PC_LSB, 2, lowest PC bit used for indexing.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_en  in  1  lookup request this cycle.
- lookup_pc  in  32  PC of the fetched branch.
- pred_valid  out  1  registered; high one cycle after a lookup.
- pred_taken  out  1  registered predicted direction.
- pred_idx  out  INDEX_BITS  registered table index used; travels with the branch.
- pred_ghr  out  HIST_BITS  registered GHR snapshot taken before the lookup's own shift; travels with the branch.
- upd_en  in  1  resolved-branch update.
- upd_idx  in  INDEX_BITS  index returned from pred_idx.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  prediction was wrong; repair the GHR.
- upd_ghr  in  HIST_BITS  snapshot returned from pred_ghr.

## Operation
- Index = lookup_pc[PC_LSB+INDEX_BITS-1:PC_LSB] XOR the GHR zero-extended to INDEX_BITS.
- Prediction = MSB of the indexed counter.
- Reset values:
  - Every counter is set to 2^(CNT_BITS-1)-1 (weakly not-taken; 01 for 2 bits).
  - GHR = 0.
  - pred_valid, pred_taken, pred_idx and pred_ghr = 0.
  - Reset is taken at the clock edge and overrides all other activity. A reset mid-operation discards any pending prediction; pred_valid is 0 in the following cycle.
- Counter update when upd_en is high:
  - upd_taken=1: increment, saturating at 2^CNT_BITS-1.
  - upd_taken=0: decrement, saturating at 0.
  - Only entry upd_idx changes.
- GHR update, in priority order:
  1. upd_en && upd_mispredict: GHR <= {upd_ghr[HIST_BITS-2:0], upd_taken}, or upd_taken alone when HIST_BITS=1. This wins over a same-cycle lookup; that lookup's prediction is still produced, but its speculative shift is dropped.
  2. lookup_en: GHR <= {GHR[HIST_BITS-2:0], predicted direction}.
  3. Otherwise GHR holds.
- upd_en with upd_mispredict=0 trains the counter only; the GHR is untouched.
- upd_mispredict is ignored while upd_en=0.
- The GHR wraps by shifting: the oldest bit is discarded.

## Timing
- Lookup in cycle N: pred_* are valid in cycle N+1. pred_valid is high for exactly one cycle per lookup_en.
- Back-to-back lookups are allowed every cycle. Lookup N+1 indexes with the GHR already shifted by lookup N.
- A counter update issued in cycle N is visible to lookups in cycle N+1.
- Same-cycle lookup and update of the same index: handled per Configuration.
- Update latency to the GHR: one cycle.

## Configuration
- GSHARE_BYPASS_EN defined: a lookup that hits the entry being updated in the same cycle uses the post-update counter value.
- GSHARE_BYPASS_EN undefined: that lookup reads the pre-update value. There is no forwarding mux.

## Test plan
- Reset: assert rst for 2 cycles, then lookup pc=0x0 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0, pred_ghr=0; following lookup shows pred_ghr=0.
- Saturation: 3 updates to idx 5 with taken=1 -> counter 01→10→11→11, and a lookup landing on idx 5 gives pred_taken=1. Then 4 updates with taken=0 -> counter floors at 00, pred_taken=0.
- Indexing: mispredict update with upd_ghr=0001, upd_taken=1 -> GHR=0011. Then lookup pc=0x14 (bits[5:2]=0101) -> pred_idx=6, pred_ghr=0011.
- Priority: same cycle lookup_en=1 and mispredict update (upd_ghr=1010, upd_taken=0) -> next lookup reports pred_ghr=0100, not the speculative value.
- Bypass: idx 3 counter=01; same-cycle update (idx 3, taken=1) and a lookup hitting idx 3 -> pred_taken=1 with GSHARE_BYPASS_EN, 0 without.
- Reset mid-operation: lookup in cycle N with rst high in cycle N -> pred_valid=0 in N+1; GHR=0 and all counters=01.
